// File: rtl/shift_reg_universal.sv
// Universal shift register with DEPTH stages of WIDTH-bit lanes.
// Supports hold, forward shift, backward shift and parallel load.
// Counts shifts within a frame of DEPTH shifts and pulses frame_done
// for one cycle after the shift that completes each frame.
module shift_reg_universal #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       sin_head,
  input  logic [WIDTH-1:0]       sin_tail,
  input  logic [WIDTH*DEPTH-1:0] pin,
  output logic [WIDTH-1:0]       sout_tail,
  output logic [WIDTH-1:0]       sout_head,
  output logic [WIDTH*DEPTH-1:0] pout,
  output logic [CW-1:0]          shift_cnt,
  output logic                   frame_done
);

  localparam logic [1:0] ModeHold = 2'b00;
  localparam logic [1:0] ModeFwd  = 2'b01;
  localparam logic [1:0] ModeBwd  = 2'b10;
  localparam logic [1:0] ModeLoad = 2'b11;

  localparam logic [CW-1:0] CntLast = CW'(DEPTH - 1);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             do_shift;

  // Next-state for stages, shift counter and frame pulse.
  always_comb begin
    stage_d  = stage_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    do_shift = 1'b0;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
      cnt_d = '0;
    end else if (en) begin
      case (mode)
        ModeHold: ;
        ModeFwd: begin
          stage_d[0] = sin_head;
          for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
          do_shift = 1'b1;
        end
        ModeBwd: begin
          stage_d[DEPTH-1] = sin_tail;
          for (int i = 0; i < DEPTH - 1; i++) stage_d[i] = stage_q[i+1];
          do_shift = 1'b1;
        end
        ModeLoad: begin
          for (int i = 0; i < DEPTH; i++) stage_d[i] = pin[i*WIDTH +: WIDTH];
          cnt_d = '0;
        end
        default: ;
      endcase
      // Forward and backward shifts share one frame counter.
      if (do_shift) begin
        if (cnt_q == CntLast) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Outputs are direct register taps.
  always_comb begin
    pout = '0;
    for (int i = 0; i < DEPTH; i++) pout[i*WIDTH +: WIDTH] = stage_q[i];
    sout_tail  = stage_q[DEPTH-1];
    sout_head  = stage_q[0];
    shift_cnt  = cnt_q;
    frame_done = done_q;
  end

endmodule

// File: tb/tb_shift_reg_universal.sv
// Self-checking bench for shift_reg_universal (WIDTH=8, DEPTH=4).
// A queue-based reference model tracks the stage contents and frame count.
module tb_shift_reg_universal;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic           clk;
  logic           reset;
  logic           clr;
  logic           en;
  logic [1:0]     mode;
  logic [W-1:0]   sin_head;
  logic [W-1:0]   sin_tail;
  logic [W*D-1:0] pin;
  logic [W-1:0]   sout_tail;
  logic [W-1:0]   sout_head;
  logic [W*D-1:0] pout;
  logic [1:0]     shift_cnt;
  logic           frame_done;

  shift_reg_universal #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .en         (en),
    .mode       (mode),
    .sin_head   (sin_head),
    .sin_tail   (sin_tail),
    .pin        (pin),
    .sout_tail  (sout_tail),
    .sout_head  (sout_head),
    .pout       (pout),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue element 0 is stage 0.
  logic [W-1:0] mq[$];
  int           m_cnt;
  logic         m_done;

  function automatic logic [W*D-1:0] model_pout();
    logic [W*D-1:0] v = '0;
    for (int i = 0; i < int'(D); i++) v[i*W +: W] = mq[i];
    return v;
  endfunction

  task automatic model_reset();
    mq = {};
    for (int i = 0; i < int'(D); i++) mq.push_back('0);
    m_cnt  = 0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic e, input logic [1:0] m,
                            input logic [W-1:0] sh, input logic [W-1:0] st,
                            input logic [W*D-1:0] p);
    if (c) begin
      model_reset();
    end else if (!e || m == 2'd0) begin
      m_done = 1'b0;
    end else if (m == 2'd3) begin
      mq = {};
      for (int i = 0; i < int'(D); i++) mq.push_back(p[i*W +: W]);
      m_cnt  = 0;
      m_done = 1'b0;
    end else begin
      if (m == 2'd1) begin
        mq.push_front(sh);
        void'(mq.pop_back());
      end else begin
        mq.push_back(st);
        void'(mq.pop_front());
      end
      m_cnt  = m_cnt + 1;
      m_done = (m_cnt == int'(D));
      m_cnt  = m_cnt % int'(D);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pout"}, pout, model_pout());
    chk({tag, ".sout_tail"}, 32'(sout_tail), 32'(mq[D-1]));
    chk({tag, ".sout_head"}, 32'(sout_head), 32'(mq[0]));
    chk({tag, ".shift_cnt"}, 32'(shift_cnt), 32'(m_cnt));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(m_done));
  endtask

  // One clock: drive inputs, take the edge, advance the model, check 1 time unit later.
  task automatic tick(input string tag, input logic c, input logic e, input logic [1:0] m,
                      input logic [W-1:0] sh, input logic [W-1:0] st,
                      input logic [W*D-1:0] p);
    clr = c; en = e; mode = m; sin_head = sh; sin_tail = st; pin = p;
    @(posedge clk);
    model_step(c, e, m, sh, st, p);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] seq [4];
    int pulses;
    int first_pulse;
    int last_pulse;
    int gap_ok;

    seq[0] = 8'd1; seq[1] = 8'd0; seq[2] = 8'd1; seq[3] = 8'd1;

    reset = 1'b1; clr = 1'b0; en = 1'b0; mode = 2'd0;
    sin_head = '0; sin_tail = '0; pin = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Forward stream 1,0,1,1 followed by zeros; sout_tail shows the stream on edges 4..7.
    for (int i = 0; i < 4; i++) tick("fwd_stream", 1'b0, 1'b1, 2'd1, seq[i], 8'hFF, '1);
    for (int i = 0; i < 3; i++) tick("fwd_drain", 1'b0, 1'b1, 2'd1, 8'd0, 8'hFF, '1);

    // Load then backward shifts with zeros entering at the tail.
    tick("load", 1'b0, 1'b1, 2'd3, 8'hEE, 8'hEE, 32'hDDCC_BBAA);
    chk("load.pout_const", pout, 32'hDDCC_BBAA);
    tick("bwd1", 1'b0, 1'b1, 2'd2, 8'h55, 8'h00, '1);
    chk("bwd1.pout_const", pout, 32'h00DD_CCBB);
    tick("bwd2", 1'b0, 1'b1, 2'd2, 8'h55, 8'h00, '1);
    tick("bwd3", 1'b0, 1'b1, 2'd2, 8'h55, 8'h00, '1);

    // Stall mid-frame: count and contents freeze, frame completes after 4th shift.
    tick("stall_clr", 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, '0);
    tick("stall_s1", 1'b0, 1'b1, 2'd1, 8'h11, 8'h00, '0);
    tick("stall_s2", 1'b0, 1'b1, 2'd1, 8'h22, 8'h00, '0);
    for (int i = 0; i < 3; i++) begin
      tick("stall_hold", 1'b0, 1'b0, 2'd1, 8'h99, 8'h99, '1);
      chk("stall.cnt_const", 32'(shift_cnt), 32'd2);
    end
    tick("stall_s3", 1'b0, 1'b1, 2'd2, 8'h33, 8'h44, '0);
    tick("stall_s4", 1'b0, 1'b1, 2'd1, 8'h55, 8'h00, '0);
    chk("stall.done_const", 32'(frame_done), 32'd1);
    tick("stall_idle", 1'b0, 1'b1, 2'd0, 8'h66, 8'h66, '1);

    // Load mid-frame resets the count; next four shifts yield exactly one pulse.
    for (int i = 0; i < 3; i++) tick("mid_shift", 1'b0, 1'b1, 2'd1, 8'(i + 7), 8'h00, '0);
    tick("mid_load", 1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 32'h0403_0201);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick("mid_after", 1'b0, 1'b1, 2'd2, 8'h00, 8'(i + 9), '0);
      if (frame_done) pulses++;
    end
    chk("mid.pulses", 32'(pulses), 32'd1);

    // clr beats en/load.
    tick("clr_prio", 1'b1, 1'b1, 2'd3, 8'hAB, 8'hCD, 32'hFFFF_FFFF);
    chk("clr.pout_const", pout, 32'd0);

    // Asynchronous reset mid-cycle while pout is nonzero.
    tick("pre_rst_load", 1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 32'h1234_5678);
    tick("pre_rst_shift", 1'b0, 1'b1, 2'd1, 8'h9A, 8'h00, '0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    reset = 1'b0;

    // Continuous forward shifting: three pulses, four cycles apart.
    pulses = 0; first_pulse = -1; last_pulse = -1; gap_ok = 1;
    for (int i = 1; i <= 12; i++) begin
      tick("cont", 1'b0, 1'b1, 2'd1, 8'(i), 8'h00, '0);
      if (frame_done) begin
        if (last_pulse >= 0 && (i - last_pulse) != 4) gap_ok = 0;
        if (first_pulse < 0) first_pulse = i;
        last_pulse = i;
        pulses++;
      end
    end
    chk("cont.pulses", 32'(pulses), 32'd3);
    chk("cont.first", 32'(first_pulse), 32'd4);
    chk("cont.spacing", 32'(gap_ok), 32'd1);

    // Randomized operation against the model.
    for (int i = 0; i < 400; i++) begin
      tick("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 32'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
